// File: rtl/use_frame_pkg.sv
// Shared frame constants and FSM encoding for the UART command-frame link.
// Both the transmitter (use_send) and the receiver import this package, so the
// two ends agree on header, trailer and frame length.
// Optional feature macro: CHECKSUM_EN adds an XOR checksum byte before the trailer.
package use_frame_pkg;

   localparam logic [7:0] HEAD0 = 8'hAB;
   localparam logic [7:0] HEAD1 = 8'hCD;
   localparam logic [7:0] TAIL  = 8'hEF;

`ifdef CHECKSUM_EN
   localparam int IDX_W     = 4;
   localparam int FRAME_LEN = 9;
`else
   localparam int IDX_W     = 3;
   localparam int FRAME_LEN = 8;
`endif

   localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // XOR of the five payload bytes {ctrl, time_ctrl}
   function automatic logic [7:0] payload_xor(input logic [39:0] p);
      return p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
   endfunction

endpackage

// File: rtl/use_send.sv
// Frame transmitter: latches {ctrl, time_ctrl} on request and feeds the UART
// byte transmitter one byte per send_en / tx_done handshake:
//   AB CD ctrl T3 T2 T1 T0 [csum] EF
// Optional feature macro: CHECKSUM_EN (9-byte frame with XOR checksum).
module use_send
   import use_frame_pkg::*;
(
   input  logic        sclk,
   input  logic        rst,
   input  logic        send_req,
   input  logic [7:0]  ctrl,
   input  logic [31:0] time_ctrl,
   input  logic        tx_done,
   output logic [7:0]  tx_data,
   output logic        tx_send_en,
   output logic        busy,
   output logic        frame_done
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [39:0]      shadow;
   logic [7:0]       cur_byte;

`ifdef CHECKSUM_EN
   logic [7:0]       csum;

   // Checksum latched together with the payload so it never sees mid-frame input changes
   always_ff @(posedge sclk or negedge rst) begin
      if (!rst)
         csum <= 8'h00;
      else if (state == IDLE && send_req)
         csum <= payload_xor({ctrl, time_ctrl});
   end
`endif

   // Byte select for the current frame position
   always_comb begin
      cur_byte = TAIL;
      case (idx)
         IDX_W'(0): cur_byte = HEAD0;
         IDX_W'(1): cur_byte = HEAD1;
         IDX_W'(2): cur_byte = shadow[39:32];
         IDX_W'(3): cur_byte = shadow[31:24];
         IDX_W'(4): cur_byte = shadow[23:16];
         IDX_W'(5): cur_byte = shadow[15:8];
         IDX_W'(6): cur_byte = shadow[7:0];
`ifdef CHECKSUM_EN
         IDX_W'(7): cur_byte = csum;
`endif
         default:   cur_byte = TAIL;
      endcase
   end

   // Frame sequencer with registered outputs
   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         idx        <= '0;
         shadow     <= '0;
         tx_data    <= 8'h00;
         tx_send_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tx_send_en <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (send_req) begin
                  shadow <= {ctrl, time_ctrl};
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= SEND;
               end
            end
            SEND: begin
               tx_data    <= cur_byte;
               tx_send_en <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               // tx_done coinciding with our own send_en pulse belongs to no byte of ours
               if (tx_done && !tx_send_en) begin
                  if (idx == LAST) begin
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= SEND;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
